mac_vec_acc: RTL and testbench

MAC_VEC_ACC -- requirements
Module: mac_vec_acc

---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_mult_stage.sv | 39 +++
 rtl/mac_vec_acc.sv | 174 +++++++++++++++++
 tb/tb_mac_vec_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type, default widths and saturation limits for mac_vec_acc
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_LEN_W  = 8;
    localparam int LIMIT_W    = 128;

    // Limits are built wide and sliced by the caller to its accumulator width.
    function automatic logic [LIMIT_W-1:0] sat_max(input int width, input logic is_signed);
        logic [LIMIT_W-1:0] ones;
        ones = {LIMIT_W{1'b1}};
        return ones >> (LIMIT_W - width + (is_signed ? 1 : 0));
    endfunction

    function automatic logic [LIMIT_W-1:0] sat_min(input int width, input logic is_signed);
        logic [LIMIT_W-1:0] one;
        one = {{(LIMIT_W-1){1'b0}}, 1'b1};
        return is_signed ? (one << (width - 1)) : '0;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// rtl/mac_mult_stage.sv - registered signed/unsigned DATA_W x DATA_W multiplier with valid bit
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic [DATA_W-1:0]     multiplicand,
    output logic [2*DATA_W-1:0]   product,
    output logic                  product_valid
);

    logic [2*DATA_W-1:0] op_a;
    logic [2*DATA_W-1:0] op_b;
    logic [2*DATA_W-1:0] product_next;

    // The low 2*DATA_W bits of the product are exact for both signednesses
    // once the operands are extended to that width.
    assign op_a         = {{DATA_W{signed_mode & multiplier[DATA_W-1]}}, multiplier};
    assign op_b         = {{DATA_W{signed_mode & multiplicand[DATA_W-1]}}, multiplicand};
    assign product_next = op_a * op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= load;
            if (load) begin
                product <= product_next;
            end
        end
    end

endmodule

// File: rtl/mac_vec_acc.sv
// rtl/mac_vec_acc.sv - vector dot-product accumulator with wrap/saturate and sticky overflow
module mac_vec_acc
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              signed_mode,
    input  logic              sat_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] multiplier,
    input  logic [DATA_W-1:0] multiplicand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy
);

    localparam int EXT_W = ACC_W - 2*DATA_W;
    localparam logic [LIMIT_W-1:0] MAX_S_W = sat_max(ACC_W, 1'b1);
    localparam logic [LIMIT_W-1:0] MAX_U_W = sat_max(ACC_W, 1'b0);
    localparam logic [LIMIT_W-1:0] MIN_S_W = sat_min(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0]   MAX_S   = MAX_S_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0]   MAX_U   = MAX_U_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0]   MIN_S   = MIN_S_W[ACC_W-1:0];

    mac_state_t state, state_next;

    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt;
    logic                signed_q;
    logic                sat_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic                ovf;
    logic                sat_hi;
    logic                sat_lo;
    logic                accept;
    logic                start_ok;
    logic [2*DATA_W-1:0] product;
    logic                product_valid;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W:0]      sum_wide;
    logic [ACC_W-1:0]    sum;
    logic                pos_ovf;
    logic                neg_ovf;

    assign start_ok = (state == IDLE) && start;
    assign accept   = in_valid && in_ready;

    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk           (clk),
        .rst           (rst),
        .load          (accept),
        .signed_mode   (signed_q),
        .multiplier    (multiplier),
        .multiplicand  (multiplicand),
        .product       (product),
        .product_valid (product_valid)
    );

    generate
        if (EXT_W > 0) begin : g_ext
            assign prod_ext = {{EXT_W{signed_q & product[2*DATA_W-1]}}, product};
        end else begin : g_noext
            assign prod_ext = product;
        end
    endgenerate

    assign sum_wide = {1'b0, acc} + {1'b0, prod_ext};
    assign sum      = sum_wide[ACC_W-1:0];

    always_comb begin
        pos_ovf  = 1'b0;
        neg_ovf  = 1'b0;
        acc_next = sum;
        if (signed_q) begin
            pos_ovf = !acc[ACC_W-1] && !prod_ext[ACC_W-1] &&  sum[ACC_W-1];
            neg_ovf =  acc[ACC_W-1] &&  prod_ext[ACC_W-1] && !sum[ACC_W-1];
        end else begin
            pos_ovf = sum_wide[ACC_W];
        end
        // Once clamped, the accumulator stays pinned in that direction until the next start.
        if (sat_q && (sat_hi || (pos_ovf && !sat_lo))) begin
            acc_next = signed_q ? MAX_S : MAX_U;
        end else if (sat_q && (sat_lo || neg_ovf)) begin
            acc_next = signed_q ? MIN_S : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = (cnt < len_q);
                if (accept && (cnt == len_q - LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!product_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            ovf      <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else if (start_ok) begin
            acc      <= '0;
            ovf      <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
            cnt      <= '0;
            len_q    <= len;
            signed_q <= signed_mode;
            sat_q    <= sat_mode;
        end else begin
            if (accept) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (product_valid) begin
                acc    <= acc_next;
                ovf    <= ovf | pos_ovf | neg_ovf;
                sat_hi <= sat_hi | (sat_q & pos_ovf & !sat_lo);
                sat_lo <= sat_lo | (sat_q & neg_ovf & !sat_hi);
            end
        end
    end

    assign result    = acc;
    assign overflow  = ovf;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mac_vec_acc.sv
// tb/tb_mac_vec_acc.sv - self-checking bench for mac_vec_acc (40-bit and 32-bit accumulator instances)
module tb_mac_vec_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        signed_mode = 1'b0;
    logic        sat_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] multiplier = 16'd0;
    logic [15:0] multiplicand = 16'd0;

    logic        in_ready, out_valid, overflow, busy;
    logic [39:0] result;
    logic        in_ready_n, out_valid_n, overflow_n, busy_n;
    logic [31:0] result_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [63:0] exp40, exp32, got40, got32;
    logic        exp_ovf40, exp_ovf32, got_ovf40, got_ovf32;

    always #5 clk = ~clk;

    mac_vec_acc #(.DATA_W(16), .ACC_W(40), .LEN_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .signed_mode(signed_mode), .sat_mode(sat_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    mac_vec_acc #(.DATA_W(16), .ACC_W(32), .LEN_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .signed_mode(signed_mode), .sat_mode(sat_mode),
        .in_valid(in_valid), .in_ready(in_ready_n),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .result(result_n), .overflow(overflow_n), .busy(busy_n)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
        end
    endtask

    // Exact integer arithmetic, then range test against the accumulator's representable interval.
    function automatic void model(input int aw, input bit sgn, input bit sat, input int n,
                                  output logic [63:0] res, output logic ovf);
        longint acc = 0;
        longint p, hi, lo, modv;
        int dir = 0;
        modv = longint'(1) << aw;
        hi   = sgn ? (modv / 2 - 1) : (modv - 1);
        lo   = sgn ? -(modv / 2) : 0;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sgn) p = longint'($signed(va[i])) * longint'($signed(vb[i]));
            else     p = longint'(va[i]) * longint'(vb[i]);
            acc = acc + p;
            if (acc > hi || acc < lo) begin
                ovf = 1'b1;
                if (sat && dir == 0) dir = (acc > hi) ? 1 : -1;
                if (!sat) begin
                    acc = acc % modv;
                    if (acc < 0) acc = acc + modv;
                    if (sgn && acc > hi) acc = acc - modv;
                end
            end
            if (dir == 1) acc = hi;
            else if (dir == -1) acc = lo;
        end
        res = acc & (modv - 1);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("res40", 64'(result), exp40);
            chk("ovf40", 64'(overflow), 64'(exp_ovf40));
            chk("busy_hold", 64'(busy), 64'd1);
        end
        if (!rst && out_valid_n) begin
            chk("res32", 64'(result_n), exp32);
            chk("ovf32", 64'(overflow_n), 64'(exp_ovf32));
        end
    end

    task automatic run_vec(input int n, input bit sgn, input bit sat, input bit bubbles, input int hold_cycles);
        bit rdy;
        int guard;
        model(40, sgn, sat, n, exp40, exp_ovf40);
        model(32, sgn, sat, n, exp32, exp_ovf32);
        start = 1'b1; len = 8'(n); signed_mode = sgn; sat_mode = sat;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("len0_valid", 64'(out_valid), 64'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (bubbles) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                in_valid = 1'b1; multiplier = va[i]; multiplicand = vb[i];
                guard = 0;
                do begin
                    @(negedge clk); rdy = in_ready;
                    @(posedge clk); #1;
                    guard++;
                end while (!rdy && guard < 16);
                chk("beat_accept", 64'(rdy), 64'd1);
            end
            in_valid = 1'b0;
            @(negedge clk);
            chk("lat1_valid", 64'(out_valid), 64'd0);
            chk("drain_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            chk("lat2_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("lat3_valid", 64'(out_valid), 64'd1);
            chk("lat3_valid32", 64'(out_valid_n), 64'd1);
        end
        got40 = 64'(result); got32 = 64'(result_n);
        got_ovf40 = overflow; got_ovf32 = overflow_n;
        for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clk); #1;
            start = (k == 1); len = 8'd3;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        va[0] = 16'd1; vb[0] = 16'd2; va[1] = 16'd2; vb[1] = 16'd2;
        va[2] = 16'd3; vb[2] = 16'd2; va[3] = 16'd4; vb[3] = 16'd2;
        run_vec(4, 1'b0, 1'b0, 1'b0, 0);
        chk("t1_res", got40, 64'd20);
        chk("t1_ovf", 64'(got_ovf40), 64'd0);

        va[0] = 16'hFFFD; vb[0] = 16'd5; va[1] = 16'd2; vb[1] = 16'd2;
        run_vec(2, 1'b1, 1'b0, 1'b1, 0);
        chk("t2_res40", got40, 64'h000000FF_FFFFFFF5);
        chk("t2_res32", got32, 64'hFFFFFFF5);
        chk("t2_ovf", 64'(got_ovf40), 64'd0);

        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
        run_vec(2, 1'b0, 1'b1, 1'b0, 0);
        chk("t3_sat_res32", got32, 64'hFFFFFFFF);
        chk("t3_sat_ovf32", 64'(got_ovf32), 64'd1);
        chk("t3_res40", got40, 64'h1_FFFC0002);
        run_vec(2, 1'b0, 1'b0, 1'b0, 0);
        chk("t3_wrap_res32", got32, 64'hFFFC0002);
        chk("t3_wrap_ovf32", 64'(got_ovf32), 64'd1);

        va[0] = 16'd5; vb[0] = 16'd5; va[1] = 16'd1; vb[1] = 16'd1;
        va[2] = 16'd2; vb[2] = 16'd3;
        run_vec(3, 1'b0, 1'b0, 1'b0, 5);
        chk("t4_res", got40, 64'd32);
        chk("t4_ovf_cleared", 64'(got_ovf32), 64'd0);

        va[0] = 16'h8000; vb[0] = 16'h8000; va[1] = 16'h8000; vb[1] = 16'h8000;
        va[2] = 16'h8000; vb[2] = 16'h8000; va[3] = 16'hFFFF; vb[3] = 16'h0001;
        run_vec(4, 1'b1, 1'b1, 1'b1, 0);
        chk("t5_satpos32", got32, 64'h7FFFFFFF);
        chk("t5_res40", got40, 64'hBFFFFFFF);

        va[0] = 16'h8000; vb[0] = 16'h7FFF; va[1] = 16'h8000; vb[1] = 16'h7FFF;
        va[2] = 16'h8000; vb[2] = 16'h7FFF;
        run_vec(3, 1'b1, 1'b1, 1'b0, 0);
        chk("t6_satneg32", got32, 64'h80000000);
        chk("t6_res40", got40, 64'hFF_40018000);

        run_vec(0, 1'b0, 1'b0, 1'b0, 0);
        chk("t7_len0_res", got40, 64'd0);
        chk("t7_len0_ovf", 64'(got_ovf40), 64'd0);

        va[0] = 16'd9; vb[0] = 16'd9; va[1] = 16'd8; vb[1] = 16'd8;
        start = 1'b1; len = 8'd4; signed_mode = 1'b0; sat_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            multiplier = va[i]; multiplicand = vb[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_result32", 64'(result_n), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        va[0] = 16'd7; vb[0] = 16'd6;
        run_vec(1, 1'b0, 1'b0, 1'b0, 0);
        chk("t8_res", got40, 64'd42);
        chk("t8_res32", got32, 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
